memc_deskew: RTL and testbench
==============================

Name: memc_deskew

Overview:
- Output-side counterpart of the systolic array's skewed B-operand feeder.
- Collects the diagonally skewed result columns leaving the array edge and realigns them, so all DIM elements of a C row appear in the same step.
- Buffers the DIM aligned rows and streams them to the host-side writer over a valid/ready handshake.
- Sits between the systolic array's C outputs and the result memory.

Parameters:
- BITS_C, 24, width of each array result element
- BITS_OUT, 16, width of each emitted element (BITS_OUT <= BITS_C)
- DIM, 8, array dimension: number of columns and number of rows per matrix

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  array step enable; deskew and capture advance only when en=1
- start  input  1  marks step 0 of a result pass; sampled only when en=1 and state is IDLE
- Cin  input  signed [BITS_C-1:0] x DIM  skewed results from the array edge
- Cout  output  signed [BITS_OUT-1:0] x DIM  aligned row at the head of the row buffer
- out_valid  output  1  Cout holds an unread row
- out_ready  input  1  consumer accepts the row when out_valid && out_ready
- busy  output  1  a pass is in progress (not IDLE)
- done  output  1  one-cycle pulse on the handshake of the last row of a pass

Behaviour:
- Reset:
  - state IDLE, step counter 0, delay lines 0, row buffer empty.
  - Cout=0, out_valid=0, busy=0, done=0.
  - Reset mid-pass aborts the pass; captured rows are discarded.
- Input skew contract: at step s (counted from the accepted start step, s=0), Cin[j] = C[s-j][j] for 0 <= s-j < DIM; otherwise don't-care.
- Deskew:
  - Column j passes through a delay line of DIM-1-j en-steps; column DIM-1 has zero delay.
  - Aligned row r appears at step r+DIM-1.
- Step counter:
  - $clog2(2*DIM) bits, increments on each en step while in SKEW or CAPTURE.
  - Holds when en=0.
- FSM:
  - IDLE -> SKEW on en && start. That cycle is step 0.
  - SKEW -> CAPTURE when step reaches DIM-1 (DIM=1 goes directly to CAPTURE).
  - CAPTURE: on each en step, the aligned row is written to the row buffer. Rows captured = step-(DIM-1).
  - CAPTURE -> DRAIN after the write at step 2*DIM-2.
  - DRAIN -> IDLE on the handshake of row DIM-1; done pulses in that same cycle.
  - start is ignored outside IDLE.
- Row buffer:
  - DIM entries, circular, write and read pointers plus a count.
  - Capacity equals one pass, so capture never overflows and no backpressure reaches the array.
  - Simultaneous write and read in one cycle are both honoured; count is unchanged.
- Output:
  - Cout/out_valid are registered from the buffer head.
  - First row: out_valid rises the cycle after the write of row 0, i.e. a 1-cycle capture-to-valid latency.
  - Cout is stable while out_valid && !out_ready.
  - With out_ready held high, one row is emitted per cycle after alignment.
- busy = (state != IDLE).
- Width: truncation or saturation from BITS_C to BITS_OUT is applied at the buffer read (see Optional Feature).

Optional Feature:
- Macro: MEMC_DESKEW_SAT_EN.
- Defined: each element is saturated to the signed BITS_OUT range, i.e. clamped to [-2^(BITS_OUT-1), 2^(BITS_OUT-1)-1].
- Undefined: each element is truncated to its low BITS_OUT bits, with wrap-around.

Decomposition:
- Shared package:
  - state enum (IDLE, SKEW, CAPTURE, DRAIN).
  - DIM/BITS_C/BITS_OUT defaults.
  - A sat function on BITS_C->BITS_OUT used by the saturate path.
- One sub-module: delay_line, parameterised by depth and width.
  - En-gated shift register.
  - Depth 0 elaborates to a wire.
  - One instance per column, depth DIM-1-j.

Test Plan:
- Basic pass, DIM=4, en=1 throughout, out_ready=1:
  - Stimulus: C[r][j] = 16*r + j driven with the skew contract.
  - Required: rows 0..3 appear as {0,1,2,3}, {16,17,18,19}, ... on consecutive cycles, the first out_valid at cycle start+4.
  - Required: done pulses with row 3; busy falls the next cycle.
- en gaps:
  - Stimulus: deassert en for 2 cycles at steps 2 and 5.
  - Required: same output rows, each delayed by the gap cycles; no row is duplicated or corrupted.
- Backpressure:
  - Stimulus: out_ready=0 until all 4 rows are captured, then toggle 1,0,1,1,1.
  - Required: Cout stable while stalled; rows emitted in order; the buffer never drops a row; done on the fourth handshake only.
- Start while busy:
  - Stimulus: pulse start at step 3.
  - Required: ignored; the pass completes unchanged; a new start accepted after done runs a second correct pass.
- Reset mid-CAPTURE:
  - Stimulus: assert rst_n low at step 5.
  - Required: out_valid=0, Cout=0, busy=0 immediately; the following pass produces clean rows with no stale data.
- Width:
  - Stimulus: C element = 0x012345 with BITS_OUT=16.
  - Required: output 0x2345 without MEMC_DESKEW_SAT_EN; output 0x7FFF with it.
  - Required: -70000 gives 0x8000 with the macro defined.

Source files
------------

// File: rtl/memc_deskew_pkg.sv
// Shared types, defaults and the saturation helper for the result deskew block.
package memc_deskew_pkg;

    localparam int DIM_DEF      = 8;
    localparam int BITS_C_DEF   = 24;
    localparam int BITS_OUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKEW    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Clamp a sign-extended value to the signed range of bits_out bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                               input int unsigned bits_out);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits_out - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bits_out - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/memc_deskew_delay_line.sv
// En-gated shift register used to undo the per-column skew; depth 0 is a plain wire.
module memc_deskew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, en};
            assign dout = din;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] sr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (en) begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++)
                        sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/memc_deskew.sv
// Realigns skewed systolic-array result columns and streams the rows out over valid/ready.
// Build option: define MEMC_DESKEW_SAT_EN to saturate elements instead of truncating them.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for en && start (that cycle is step 0)
// SKEW    | delay lines filling, no aligned row yet
// CAPTURE | one aligned row written to the buffer per en step
// DRAIN   | all rows captured, waiting for the last handshake
module memc_deskew
    import memc_deskew_pkg::*;
#(
    parameter int BITS_C   = BITS_C_DEF,
    parameter int BITS_OUT = BITS_OUT_DEF,
    parameter int DIM      = DIM_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         start,
    input  logic [DIM-1:0][BITS_C-1:0]   Cin,
    output logic [DIM-1:0][BITS_OUT-1:0] Cout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int SW = $clog2(2 * DIM);
    localparam int PW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW = $clog2(DIM + 1);

    state_t                     state;
    state_t                     state_nx;
    logic [SW-1:0]              step;
    logic [SW-1:0]              step_nx;
    logic [SW-1:0]              cur_step;
    logic                       in_pass;
    logic                       wr;
    logic                       rd;
    logic [DIM-1:0][BITS_C-1:0] aligned;
    logic [DIM-1:0][BITS_C-1:0] mem [DIM];
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [CW-1:0]              count;

    generate
        for (genvar j = 0; j < DIM; j++) begin : g_col
            memc_deskew_delay_line #(
                .DEPTH(DIM - 1 - j),
                .WIDTH(BITS_C)
            ) u_dly (
                .clk  (clk),
                .rst_n(rst_n),
                .en   (en),
                .din  (Cin[j]),
                .dout (aligned[j])
            );
        end
    endgenerate

    // The start cycle is step 0 even though the register still reads IDLE.
    assign cur_step  = (state == IDLE) ? '0 : step;
    assign in_pass   = (state == SKEW) || (state == CAPTURE) || ((state == IDLE) && start);
    assign wr        = en && in_pass && (cur_step >= SW'(DIM - 1));
    assign out_valid = (count != '0);
    assign rd        = out_valid && out_ready;
    // The last row is written before DRAIN, so a read of count 1 there is row DIM-1.
    assign done      = (state == DRAIN) && rd && (count == CW'(1));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        step_nx  = step;
        case (state)
            IDLE, SKEW, CAPTURE: begin
                if (en && in_pass) begin
                    step_nx = cur_step + SW'(1);
                    if (wr && (cur_step == SW'(2 * DIM - 2)))
                        state_nx = DRAIN;
                    else if ((cur_step + SW'(1)) >= SW'(DIM - 1))
                        state_nx = CAPTURE;
                    else
                        state_nx = SKEW;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_nx = IDLE;
                    step_nx  = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                step_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DIM - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DIM; i++)
                mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= aligned;
                wptr      <= ptr_inc(wptr);
            end
            if (rd)
                rptr <= ptr_inc(rptr);
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        Cout = '0;
        if (out_valid) begin
            for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_DESKEW_SAT_EN
                Cout[j] = BITS_OUT'(sat(64'($signed(mem[rptr][j])), BITS_OUT));
`else
                Cout[j] = BITS_OUT'(mem[rptr][j]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_memc_deskew.sv
// Directed bench for memc_deskew at DIM=4: timing, en gaps, backpressure, restart, reset and width.
module tb_memc_deskew;

    localparam int DIM = 4;
    localparam int BC  = 24;
    localparam int BO  = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic                   start;
    logic [DIM-1:0][BC-1:0] Cin;
    logic [DIM-1:0][BO-1:0] Cout;
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;
    logic                   done;

    logic [BC-1:0] mat [DIM][DIM];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memc_deskew #(.BITS_C(BC), .BITS_OUT(BO), .DIM(DIM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .Cin      (Cin),
        .Cout     (Cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    function automatic logic [BO-1:0] exp_elem(input logic [BC-1:0] v);
`ifdef MEMC_DESKEW_SAT_EN
        int sv;
        sv = int'($signed(v));
        if (sv > 32767)
            return 16'h7FFF;
        else if (sv < -32768)
            return 16'h8000;
        else
            return sv[15:0];
`else
        return v[BO-1:0];
`endif
    endfunction

    function automatic logic [DIM-1:0][BO-1:0] row_exp(input int r);
        logic [DIM-1:0][BO-1:0] x;
        for (int j = 0; j < DIM; j++)
            x[j] = exp_elem(mat[r][j]);
        return x;
    endfunction

    // Skew contract: step s carries C[s-j][j] on column j; everything else is junk.
    function automatic logic [DIM-1:0][BC-1:0] skew(input int s);
        logic [DIM-1:0][BC-1:0] x;
        for (int j = 0; j < DIM; j++)
            x[j] = (s - j >= 0 && s - j < DIM) ? mat[s-j][j] : 24'hABCDEF;
        return x;
    endfunction

    task automatic fill_mat(input int base, input int rs);
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++)
                mat[r][j] = BC'(base + rs * r + j);
    endtask

    task automatic drive(input logic e, input logic st, input logic rdy, input int s);
        @(posedge clk);
        #1;
        en        = e;
        start     = st;
        out_ready = rdy;
        Cin       = skew(s);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; start = 1'b0; out_ready = 1'b0; Cin = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || Cout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_in got valid=%b cout=%h busy=%b done=%b exp all 0", out_valid, Cout, busy, done);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b0 || Cout !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_out got valid=%b cout=%h busy=%b done=%b exp all 0", out_valid, Cout, busy, done);
        end
    endtask

    task automatic test_basic();
        fill_mat(0, 16);
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, c == 0, 1'b1, c);
            checks++;
            if (out_valid !== (c >= 4 && c <= 7)) begin
                failures++;
                $display("FAIL basic_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 7));
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (Cout !== row_exp(c - 4)) begin
                    failures++;
                    $display("FAIL basic_row c=%0d got=%h exp=%h", c, Cout, row_exp(c - 4));
                end
            end
            checks++;
            if (done !== (c == 7)) begin
                failures++;
                $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, (c == 7));
            end
            checks++;
            if (busy !== (c >= 1 && c <= 7)) begin
                failures++;
                $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, (c >= 1 && c <= 7));
            end
        end
    endtask

    task automatic test_en_gaps();
        int   s  = 0;
        int   rd = 0;
        logic e;
        logic ev;
        fill_mat(0, 16);
        for (int c = 0; c < 14; c++) begin
            e = !(c == 2 || c == 3 || c == 7 || c == 8);
            drive(e, c == 0, 1'b1, s);
            if (e) s++;
            ev = (c == 6 || c == 7 || c == 10 || c == 11);
            checks++;
            if (out_valid !== ev) begin
                failures++;
                $display("FAIL gap_valid c=%0d got=%b exp=%b", c, out_valid, ev);
            end
            if (out_valid === 1'b1 && rd < DIM) begin
                checks++;
                if (Cout !== row_exp(rd)) begin
                    failures++;
                    $display("FAIL gap_row c=%0d row=%0d got=%h exp=%h", c, rd, Cout, row_exp(rd));
                end
                rd++;
            end
            checks++;
            if (done !== (c == 11)) begin
                failures++;
                $display("FAIL gap_done c=%0d got=%b exp=%b", c, done, (c == 11));
            end
        end
        checks++;
        if (rd != DIM) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=%0d", rd, DIM);
        end
    endtask

    task automatic test_backpressure();
        int   rd = 0;
        logic rdy;
        fill_mat(24'h000500, 7);
        for (int c = 0; c < 14; c++) begin
            rdy = (c >= 7) && (c != 8);
            drive(1'b1, c == 0, rdy, c);
            checks++;
            if (out_valid !== (c >= 4 && c <= 11)) begin
                failures++;
                $display("FAIL bp_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 11));
            end
            if (out_valid === 1'b1 && rd < DIM) begin
                checks++;
                if (Cout !== row_exp(rd)) begin
                    failures++;
                    $display("FAIL bp_row c=%0d row=%0d got=%h exp=%h", c, rd, Cout, row_exp(rd));
                end
                if (rdy) rd++;
            end
            checks++;
            if (done !== (c == 11)) begin
                failures++;
                $display("FAIL bp_done c=%0d got=%b exp=%b", c, done, (c == 11));
            end
        end
        checks++;
        if (rd != DIM || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_end got rows=%0d busy=%b exp rows=%0d busy=0", rd, busy, DIM);
        end
    endtask

    task automatic test_start_busy();
        fill_mat(24'h000100, 16);
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 0 || c == 3, 1'b1, c);
            checks++;
            if (out_valid !== (c >= 4 && c <= 7)) begin
                failures++;
                $display("FAIL sb_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 7));
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (Cout !== row_exp(c - 4)) begin
                    failures++;
                    $display("FAIL sb_row c=%0d got=%h exp=%h", c, Cout, row_exp(c - 4));
                end
            end
            checks++;
            if (done !== (c == 7) || busy !== (c >= 1 && c <= 7)) begin
                failures++;
                $display("FAIL sb_ctl c=%0d got done=%b busy=%b exp done=%b busy=%b", c, done, busy, (c == 7), (c >= 1 && c <= 7));
            end
        end
        fill_mat(24'h000200, 3);
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 0, 1'b1, c);
            if (c >= 4 && c <= 7) begin
                checks++;
                if (out_valid !== 1'b1 || Cout !== row_exp(c - 4)) begin
                    failures++;
                    $display("FAIL sb2_row c=%0d got v=%b %h exp v=1 %h", c, out_valid, Cout, row_exp(c - 4));
                end
            end
            checks++;
            if (done !== (c == 7)) begin
                failures++;
                $display("FAIL sb2_done c=%0d got=%b exp=%b", c, done, (c == 7));
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_mat(24'h000300, 16);
        for (int c = 0; c < 6; c++)
            drive(1'b1, c == 0, 1'b0, c);
        checks++;
        if (out_valid !== 1'b1 || Cout !== row_exp(0)) begin
            failures++;
            $display("FAIL rm_pre got v=%b %h exp v=1 %h", out_valid, Cout, row_exp(0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Cout !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got v=%b cout=%h busy=%b exp 0/0/0", out_valid, Cout, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill_mat(24'h000400, 16);
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 0, 1'b1, c);
            checks++;
            if (out_valid !== (c >= 4 && c <= 7)) begin
                failures++;
                $display("FAIL rm_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 7));
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (Cout !== row_exp(c - 4)) begin
                    failures++;
                    $display("FAIL rm_row c=%0d got=%h exp=%h", c, Cout, row_exp(c - 4));
                end
            end
        end
    endtask

    task automatic test_width();
        logic [BO-1:0] e_pos;
        logic [BO-1:0] e_neg;
        logic [BO-1:0] e;
`ifdef MEMC_DESKEW_SAT_EN
        e_pos = 16'h7FFF;
        e_neg = 16'h8000;
`else
        e_pos = 16'h2345;
        e_neg = 16'hEE90;
`endif
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++)
                mat[r][j] = (r == 2) ? 24'hFEEE90 : 24'h012345;
        for (int c = 0; c < 9; c++) begin
            drive(1'b1, c == 0, 1'b1, c);
            if (c >= 4 && c <= 7) begin
                e = (c == 6) ? e_neg : e_pos;
                for (int j = 0; j < DIM; j++) begin
                    checks++;
                    if (out_valid !== 1'b1 || Cout[j] !== e) begin
                        failures++;
                        $display("FAIL width c=%0d col=%0d got v=%b %h exp v=1 %h", c, j, out_valid, Cout[j], e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_en_gaps();
        drive(1'b0, 1'b0, 1'b1, 0);
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_width();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
